hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline; sits beside the forwarding unit and drives the enables and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves the three hazards that forwarding cannot cover: load-use stall, taken-branch squash, and multi-cycle MUL/DIV occupancy of EX.
- Sequences the multi-cycle unit (MDU) with a start pulse and a latency counter, and keeps a stall-cycle performance counter.

Parameters:
MDU_LATENCY, 4, total cycles a MUL/DIV occupies EX; legal range 2..255
CNT_W, 16, width of stall_count

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_ex_valid  in  1  ID/EX holds a real (non-bubble) instruction
id_ex_rd  in  5  destination register of EX instruction
id_ex_mem_read  in  1  EX instruction is a load
id_ex_muldiv  in  1  EX instruction is MUL/DIV
ex_branch_taken  in  1  EX resolved a taken branch/jump (redirect this cycle)
stat_clr  in  1  synchronous clear of stall_count
pc_write  out  1  1 = PC may update
if_id_write  out  1  1 = IF/ID may load
if_id_flush  out  1  IF/ID loads a bubble
id_ex_flush  out  1  ID/EX loads a bubble
ex_hold  out  1  ID/EX holds; EX instruction stays in EX
ex_mem_bubble  out  1  EX/MEM loads a bubble
mdu_start  out  1  one-cycle MDU launch pulse
mdu_busy  out  1  FSM in BUSY
stall_count  out  CNT_W  cycles with pc_write=0, saturating

Behaviour:
- Registered state: fsm {IDLE, BUSY}, 8-bit down-counter cnt, stall_count. All outputs are combinational from the state and the inputs.
- Reset (async, rst_n=0): fsm=IDLE, cnt=0, stall_count=0. With all inputs 0, the outputs are pc_write=1, if_id_write=1, all others 0.
- Priority, highest first: MDU (start or busy), then branch, then load-use.

MDU start:
- Condition: IDLE and id_ex_valid and id_ex_muldiv.
- Outputs: mdu_start=1, ex_hold=1, ex_mem_bubble=1, pc_write=0, if_id_write=0.
- Next state: fsm=BUSY, cnt=MDU_LATENCY-2.

BUSY:
- mdu_busy=1 and mdu_start=0.
- While cnt!=0: ex_hold=1, ex_mem_bubble=1, pc_write=0, if_id_write=0; cnt decrements.
- cnt==0 (release cycle): ex_hold=0, ex_mem_bubble=0, pc_write=1, if_id_write=1; next fsm=IDLE.
- Resulting EX occupancy is exactly MDU_LATENCY cycles, with MDU_LATENCY-1 stall cycles.
- ex_branch_taken and load-use conditions are ignored throughout BUSY, including the release cycle.
- A MUL/DIV arriving in EX on the cycle after release launches immediately (back-to-back allowed).

Branch (IDLE, no MDU start, ex_branch_taken=1):
- Outputs: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1.
- Two bubbles total; redirect target is selected outside this block.

Load-use:
- Condition: IDLE, no MDU start, no branch, id_ex_valid, id_ex_mem_read, id_ex_rd!=0, and (id_use_rs1 and id_rs1==id_ex_rd) or (id_use_rs2 and id_rs2==id_ex_rd).
- Outputs: pc_write=0, if_id_write=0, id_ex_flush=1.
- Lasts exactly one cycle, because the load leaves EX next cycle and forwarding covers the rest.
- Never triggers for rd=x0, for id_ex_valid=0, or for an unused source field that happens to match.

Outputs and counters:
- ex_hold and if_id_flush are never 1 together. id_ex_flush is never 1 while ex_hold=1.
- stall_count: stat_clr=1 sets it to 0 (wins over increment). Otherwise it increments on every cycle with pc_write=0 and saturates at all-ones (no wrap).

Reset mid-operation:
- Reset during BUSY aborts to IDLE and cnt=0; no mdu_start follows unless a valid MUL/DIV is present after reset.

Test Plan:
1. Reset release, all inputs 0 -> pc_write=1, if_id_write=1, all flush/hold/start=0, stall_count=0.
2. Load x5 in EX (id_ex_mem_read=1, rd=5); ID uses rs2=5 -> exactly one cycle of pc_write=0 and id_ex_flush=1. Repeat with rd=0, or with id_use_rs2=0 -> no stall.
3. MUL in EX, MDU_LATENCY=4 -> mdu_start high one cycle; ex_hold=1 for 3 cycles, released on cycle 4; stall_count +=3. Second MUL immediately after -> restarts, total 6 stalls.
4. ex_branch_taken=1 while the ID instruction also has a load-use match -> if_id_flush=1, id_ex_flush=1, pc_write=1; load-use suppressed. ex_branch_taken=1 during BUSY -> ignored.
5. rst_n low during BUSY (cnt=1), then deassert with id_ex_valid=0 -> IDLE, mdu_busy=0, no mdu_start, stall_count=0.
6. Force stall_count to all-ones minus 1, then 3 stall cycles -> saturates at all-ones. stat_clr together with a stall -> 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use stall, taken-branch squash,
// multi-cycle MUL/DIV occupancy of EX, and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_ex_valid,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_muldiv,
    input  logic             ex_branch_taken,
    input  logic             stat_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_hold,
    output logic             ex_mem_bubble,
    output logic             mdu_start,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_count
);

    // Handshake: mdu_start is a single-cycle launch pulse; the MDU owns EX until
    // the release cycle, where ex_hold drops and the result moves on to EX/MEM.
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;

    logic rs_match;
    logic load_use;
    logic mdu_go;

    assign rs_match = (id_use_rs1 && (id_rs1 == id_ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == id_ex_rd));
    assign mdu_go   = (state == IDLE) && id_ex_valid && id_ex_muldiv;
    assign load_use = id_ex_valid && id_ex_mem_read && (id_ex_rd != 5'd0) && rs_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_hold       = 1'b0;
        ex_mem_bubble = 1'b0;
        mdu_start     = 1'b0;
        mdu_busy      = 1'b0;
        case (state)
            IDLE: begin
                if (mdu_go) begin
                    mdu_start     = 1'b1;
                    ex_hold       = 1'b1;
                    ex_mem_bubble = 1'b1;
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    state_next    = BUSY;
                    cnt_next      = 8'(MDU_LATENCY - 2);
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            BUSY: begin
                // Branch and load-use inputs are deliberately ignored while the MDU owns EX.
                mdu_busy = 1'b1;
                if (cnt != 8'd0) begin
                    ex_hold       = 1'b1;
                    ex_mem_bubble = 1'b1;
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    cnt_next      = cnt - 8'd1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stat_clr) begin
            stall_count <= '0;
        end else if (!pc_write && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each cycle applies inputs, checks the packed
// output vector against a hand-computed value, then checks the stall counter.
module tb_hazard_ctrl;

    localparam int LAT   = 4;
    localparam int CNT_W = 4;

    // Packed outputs: {pc_write, if_id_write, if_id_flush, id_ex_flush,
    //                  ex_hold, ex_mem_bubble, mdu_start, mdu_busy}
    localparam logic [7:0] O_IDLE  = 8'b1100_0000;
    localparam logic [7:0] O_LU    = 8'b0001_0000;
    localparam logic [7:0] O_BR    = 8'b1111_0000;
    localparam logic [7:0] O_START = 8'b0000_1110;
    localparam logic [7:0] O_BUSY  = 8'b0000_1101;
    localparam logic [7:0] O_REL   = 8'b1100_0001;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs1, id_rs2, id_ex_rd;
    logic             id_use_rs1, id_use_rs2, id_ex_valid, id_ex_mem_read;
    logic             id_ex_muldiv, ex_branch_taken, stat_clr;
    logic             pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic             ex_hold, ex_mem_bubble, mdu_start, mdu_busy;
    logic [CNT_W-1:0] stall_count;
    logic [7:0]       outs;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [CNT_W-1:0] exp_cnt  = '0;
    logic [7:0]       exp_q[$];

    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_flush,
                   ex_hold, ex_mem_bubble, mdu_start, mdu_busy};

    hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_ex_valid(id_ex_valid), .id_ex_rd(id_ex_rd),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_muldiv(id_ex_muldiv),
        .ex_branch_taken(ex_branch_taken), .stat_clr(stat_clr),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_hold(ex_hold), .ex_mem_bubble(ex_mem_bubble),
        .mdu_start(mdu_start), .mdu_busy(mdu_busy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_ex_valid = 1'b0; id_ex_mem_read = 1'b0; id_ex_muldiv = 1'b0;
        ex_branch_taken = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2);
        clear_inputs();
        id_ex_valid = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = rd;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    endtask

    // Inputs are already applied (posedge+1); check outputs, clock, check counter.
    task automatic cycle(input string tag, input logic [7:0] exp_outs);
        #1;
        check(tag, 32'(outs), 32'(exp_outs));
        @(posedge clk);
        if (stat_clr) exp_cnt = '0;
        else if (!exp_outs[7] && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        #1;
        check({tag, "_cnt"}, 32'(stall_count), 32'(exp_cnt));
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", 32'(outs), 32'(O_IDLE));
        check("rst_cnt", 32'(stall_count), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        cycle("idle", O_IDLE);

        // Load-use: one stall when the dependent ID instruction sees the load
        set_load(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        cycle("lu_rs2", O_LU);
        clear_inputs();
        cycle("lu_after", O_IDLE);
        set_load(5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        cycle("lu_x0", O_IDLE);
        set_load(5'd5, 5'd3, 1'b1, 5'd5, 1'b0);
        cycle("lu_unused", O_IDLE);
        set_load(5'd9, 5'd9, 1'b1, 5'd1, 1'b1);
        cycle("lu_rs1", O_LU);
        set_load(5'd9, 5'd9, 1'b1, 5'd1, 1'b1);
        id_ex_valid = 1'b0;
        cycle("lu_invalid", O_IDLE);
        set_load(5'd9, 5'd9, 1'b0, 5'd1, 1'b0);
        id_ex_mem_read = 1'b0; id_use_rs1 = 1'b1;
        cycle("lu_not_load", O_IDLE);

        // Two back-to-back MUL/DIVs
        exp_q.push_back(O_START); exp_q.push_back(O_BUSY);
        exp_q.push_back(O_BUSY);  exp_q.push_back(O_REL);
        exp_q.push_back(O_START); exp_q.push_back(O_BUSY);
        exp_q.push_back(O_BUSY);  exp_q.push_back(O_REL);
        clear_inputs();
        id_ex_valid = 1'b1; id_ex_muldiv = 1'b1;
        while (exp_q.size() > 0) cycle("mdu_seq", exp_q.pop_front());
        clear_inputs();
        cycle("mdu_done", O_IDLE);
        check("mdu_6_stalls", 32'(stall_count), 32'(2 + 6));

        // Branch outranks load-use; branch ignored during BUSY
        set_load(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
        ex_branch_taken = 1'b1;
        cycle("br_over_lu", O_BR);
        clear_inputs();
        id_ex_valid = 1'b1; id_ex_muldiv = 1'b1;
        cycle("br_mdu_start", O_START);
        ex_branch_taken = 1'b1;
        cycle("br_in_busy", O_BUSY);
        cycle("br_in_busy2", O_BUSY);
        cycle("br_in_release", O_REL);
        clear_inputs();
        cycle("br_clear", O_IDLE);

        // Reset while BUSY with cnt=1
        id_ex_valid = 1'b1; id_ex_muldiv = 1'b1;
        cycle("rst_mdu_start", O_START);
        cycle("rst_mdu_busy", O_BUSY);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        check("rst_mid_outs", 32'(outs), 32'(O_IDLE));
        check("rst_mid_cnt", 32'(stall_count), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle("rst_post1", O_IDLE);
        cycle("rst_post2", O_IDLE);

        // Saturation: drive continuous load-use stalls past all-ones
        for (int i = 0; i < 17; i++) begin
            set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
            cycle("sat_stall", O_LU);
        end
        check("sat_value", 32'(stall_count), 32'({CNT_W{1'b1}}));
        set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        stat_clr = 1'b1;
        cycle("clr_wins", O_LU);
        check("clr_value", 32'(stall_count), 32'(0));
        clear_inputs();
        cycle("final_idle", O_IDLE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
